// File: rtl/flt_to_int_seq.sv
// Multi-cycle float -> saturating two's-complement integer converter.
// Alignment is done by a serial shifter, one bit position per clock.
module flt_to_int_seq #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned INT_W = 16,
  parameter int          BIAS  = 15
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [EXP_W+MAN_W:0]   flt_i,
  input  logic                   rmode_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [INT_W-1:0]       int_o,
  output logic                   ovf_o,
  output logic                   inexact_o,
  output logic                   invalid_o,
  output logic                   done_o
);

  localparam int unsigned W_A = EXP_W;
  localparam int unsigned W_B = $clog2(MAN_W + 3);
  localparam int unsigned W_C = $clog2(INT_W);
  localparam int unsigned W_AB = (W_A > W_B) ? W_A : W_B;
  localparam int unsigned EW = ((W_AB > W_C) ? W_AB : W_C) + 2;

  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_SUB  = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] E_MAN  = EW'(MAN_W);
  localparam logic signed [EW-1:0] E_MAX  = EW'(INT_W - 2);
  localparam logic signed [EW-1:0] E_RCAP = EW'(MAN_W + 2);
  localparam logic [INT_W:0]       MAG_LIM = (INT_W+1)'(1) << (INT_W - 1);
  localparam logic [INT_W-1:0]     SAT_POS = {1'b0, {(INT_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, HOLD} state_t;
  state_t state, state_nxt;

  logic                 sign_q, rmode_q, left_q, sat_q, nan_q;
  logic                 guard_q, sticky_q;
  logic [EW-1:0]        k_q;
  logic [INT_W-1:0]     mag_q, int_q;
  logic                 out_valid_q, ovf_q, inexact_q, invalid_q, done_q;

  logic                 f_sign;
  logic [EXP_W-1:0]     f_exp;
  logic [MAN_W-1:0]     f_man;
  logic signed [EW-1:0] f_e, r_dist;
  logic [EW-1:0]        acc_k;
  logic                 acc_left, acc_sat, acc_nan, acc_zero;
  logic [INT_W-1:0]     acc_mag;

  // Operand decode: shift direction/count and special-operand classification.
  always_comb begin
    f_sign   = flt_i[EXP_W+MAN_W];
    f_exp    = flt_i[EXP_W+MAN_W-1 -: EXP_W];
    f_man    = flt_i[MAN_W-1:0];
    f_e      = (f_exp == '0) ? E_SUB : (signed'(EW'(f_exp)) - E_BIAS);
    r_dist   = E_MAN - f_e;
    acc_left = (f_e >= E_MAN);
    acc_mag  = INT_W'({(f_exp != '0), f_man});
    acc_k    = '0;
    acc_sat  = 1'b0;
    acc_nan  = 1'b0;
    acc_zero = 1'b0;
    if (f_exp == '1) begin
      if (f_man == '0) acc_sat = 1'b1;
      else             acc_nan = 1'b1;
    end else if ((f_exp == '0) && (f_man == '0)) begin
      acc_zero = 1'b1;
    end else if (f_e > E_MAX) begin
      acc_sat = 1'b1;
    end else if (acc_left) begin
      acc_k = unsigned'(f_e - E_MAN);
    end else if (r_dist > E_RCAP) begin
      acc_k = unsigned'(E_RCAP);
    end else begin
      acc_k = unsigned'(r_dist);
    end
  end

  logic             rnd_inc, rnd_ovf, rnd_inexact;
  logic [INT_W:0]   rnd_mag;
  logic [INT_W-1:0] rnd_int;

  always_comb begin
    rnd_inc     = rmode_q & guard_q & (sticky_q | mag_q[0]);
    rnd_mag     = {1'b0, mag_q} + (INT_W+1)'(rnd_inc);
    rnd_ovf     = 1'b0;
    rnd_inexact = 1'b0;
    rnd_int     = '0;
    if (!nan_q) begin
      rnd_inexact = guard_q | sticky_q;
      rnd_ovf     = sat_q | (rnd_mag >= MAG_LIM);
      if (rnd_ovf) rnd_int = sign_q ? ('0 - SAT_POS) : SAT_POS;
      else         rnd_int = sign_q ? ('0 - rnd_mag[INT_W-1:0]) : rnd_mag[INT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid_i) state_nxt = (acc_k != '0) ? SHIFT : ROUND;
      SHIFT:   if (k_q == EW'(1)) state_nxt = ROUND;
      ROUND:   state_nxt = HOLD;
      HOLD:    if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sign_q      <= 1'b0;
      rmode_q     <= 1'b0;
      left_q      <= 1'b0;
      sat_q       <= 1'b0;
      nan_q       <= 1'b0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      k_q         <= '0;
      mag_q       <= '0;
      int_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      inexact_q   <= 1'b0;
      invalid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (in_valid_i) begin
          sign_q    <= f_sign;
          rmode_q   <= rmode_i;
          left_q    <= acc_left;
          sat_q     <= acc_sat;
          nan_q     <= acc_nan;
          k_q       <= acc_k;
          mag_q     <= (acc_sat | acc_nan | acc_zero) ? '0 : acc_mag;
          guard_q   <= 1'b0;
          sticky_q  <= 1'b0;
          ovf_q     <= 1'b0;
          inexact_q <= 1'b0;
          invalid_q <= 1'b0;
        end
        SHIFT: begin
          k_q <= k_q - EW'(1);
          if (left_q) begin
            mag_q <= mag_q << 1;
          end else begin
            // Previous guard ages into sticky; the bit leaving now becomes guard.
            mag_q    <= mag_q >> 1;
            guard_q  <= mag_q[0];
            sticky_q <= sticky_q | guard_q;
          end
        end
        ROUND: begin
          int_q       <= rnd_int;
          ovf_q       <= rnd_ovf;
          inexact_q   <= rnd_inexact;
          invalid_q   <= nan_q;
          out_valid_q <= 1'b1;
        end
        HOLD: if (out_ready_i) begin
          out_valid_q <= 1'b0;
          done_q      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = out_valid_q;
  assign int_o       = int_q;
  assign ovf_o       = ovf_q;
  assign inexact_o   = inexact_q;
  assign invalid_o   = invalid_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_flt_to_int_seq.sv
// Scoreboard bench for flt_to_int_seq: driver pushes model results, monitor pops on output.
module tb_flt_to_int_seq;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int INT_W = 16;
  localparam int BIAS  = 15;

  logic        clk_i = 1'b0;
  logic        reset_i, in_valid_i, in_ready_o, rmode_i;
  logic        out_valid_o, out_ready_i, ovf_o, inexact_o, invalid_o, done_o;
  logic [15:0] flt_i, int_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rand_ready = 1'b0;
  int bp_hold = 0;

  typedef struct {
    logic [15:0] v;
    bit          ovf;
    bit          inx;
    bit          inv;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  flt_to_int_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W), .INT_W(INT_W), .BIAS(BIAS)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .flt_i(flt_i), .rmode_i(rmode_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .int_o(int_o), .ovf_o(ovf_o), .inexact_o(inexact_o), .invalid_o(invalid_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Exact value = M * 2^(e-10); round from the exact remainder.
  function automatic exp_t model(input logic [15:0] f, input bit rm);
    exp_t   r;
    longint m, q, rem, half, mag;
    int     e, sh;
    r.v = '0; r.ovf = 0; r.inx = 0; r.inv = 0; r.lat = 1; r.acc = 0;
    if (f[14:10] == 5'h1f) begin
      if (f[9:0] == 10'd0) begin
        r.ovf = 1;
        r.v = f[15] ? 16'h8001 : 16'h7fff;
      end else begin
        r.inv = 1;
      end
      return r;
    end
    m = (f[14:10] != 5'd0) ? 1024 + longint'(f[9:0]) : longint'(f[9:0]);
    e = (f[14:10] != 5'd0) ? int'(f[14:10]) - 15 : -14;
    if (m == 0) return r;
    if (e > 14) begin
      r.ovf = 1;
      r.v = f[15] ? 16'h8001 : 16'h7fff;
      return r;
    end
    if (e >= 10) begin
      mag = m << (e - 10);
      r.lat = e - 10 + 1;
    end else begin
      sh = 10 - e;
      q = m >> sh;
      rem = m - (q << sh);
      half = longint'(1) << (sh - 1);
      r.inx = (rem != 0);
      if (rm && (rem > half || (rem == half && q[0]))) q++;
      mag = q;
      r.lat = ((sh > 12) ? 12 : sh) + 1;
    end
    if (mag >= 32768) begin
      r.ovf = 1;
      r.v = f[15] ? 16'h8001 : 16'h7fff;
    end else begin
      r.v = f[15] ? 16'(-mag) : 16'(mag);
    end
    return r;
  endfunction

  task automatic send(input logic [15:0] f, input bit rm);
    exp_t e;
    int   n = 0;
    while (!in_ready_o) begin
      in_valid_i = 1'($urandom);
      flt_i      = 16'($urandom);
      rmode_i    = 1'($urandom);
      @(posedge clk_i); #1;
      n++;
      if (n > 200) begin
        chk("accept_wait", 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b0;
        return;
      end
    end
    in_valid_i = 1'b1;
    flt_i      = f;
    rmode_i    = rm;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    flt_i      = 16'($urandom);
    e = model(f, rm);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready_o) && n < 500) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      if (bp_hold > 0) begin
        out_ready_i = 1'b0;
        if (out_valid_o) bp_hold--;
      end else begin
        out_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  bit          prev_valid = 0;
  bit          prev_hs = 0;
  logic [15:0] held;
  exp_t        got;

  always @(negedge clk_i) begin
    if (!reset_i) begin
      prev_valid = 0;
      prev_hs = 0;
    end else begin
      chk("done", 32'(done_o), 32'(prev_hs));
      if (prev_hs) chk("valid_drop", 32'(out_valid_o), 32'd0);
      if (out_valid_o) begin
        chk("busy_ready", 32'(in_ready_o), 32'd0);
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out actual=%0h required=none", int_o);
          end else begin
            got = sb.pop_front();
            chk("int",     32'(int_o),     32'(got.v));
            chk("ovf",     32'(ovf_o),     32'(got.ovf));
            chk("inexact", 32'(inexact_o), 32'(got.inx));
            chk("invalid", 32'(invalid_o), 32'(got.inv));
            chk("latency", 32'(cyc - got.acc), 32'(got.lat));
          end
          held = int_o;
        end else begin
          chk("hold_int", 32'(int_o), 32'(held));
        end
      end
      prev_valid = out_valid_o;
      prev_hs = out_valid_o && out_ready_i;
    end
  end

  logic [15:0] dv[13] = '{16'hC204, 16'h4100, 16'h4300, 16'h4100, 16'h4300, 16'h77FF, 16'h7800,
                          16'hF800, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0001, 16'h8000};
  bit          dr[13] = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    reset_i = 1'b0; in_valid_i = 1'b0; flt_i = '0; rmode_i = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_int",   32'(int_o), 32'd0);
    chk("rst_flags", 32'({ovf_o, inexact_o, invalid_o}), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    reset_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 13; i++) send(dv[i], dr[i]);
    drain();

    bp_hold = 3;
    send(16'h4300, 1'b1);
    drain();

    send(16'hC204, 1'b0);
    repeat (4) @(posedge clk_i);
    #3 reset_i = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready_o), 32'd1);
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_int",   32'(int_o), 32'd0);
    chk("mid_rst_flags", 32'({ovf_o, inexact_o, invalid_o, done_o}), 32'd0);
    sb.delete();
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    send(16'hC204, 1'b0);
    send(16'h4100, 1'b1);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) send(16'($urandom), 1'($urandom));
    drain();
    rand_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
